// File: rtl/secuenciador_alu.sv
// secuenciador_alu: this controller sits in front of the ROM/ALU/7-segment datapath.
// It sweeps every (A,B) address pair in row-major order. After each address change
// it waits LAT extra settle cycles, then captures the ALU result and carry.
// The sweep runs either automatically or one step per button pulse, and it keeps
// an XOR signature of every result captured during the current sweep.
module secuenciador_alu #(
  parameter int DIR_W = 4,
  parameter int N     = 32,
  parameter int LAT   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             modo_i,
  input  logic             paso_i,
  input  logic [1:0]       operacion_i,
  input  logic [N-1:0]     resultado_i,
  input  logic             c_alu_i,
  output logic [DIR_W-1:0] dira_o,
  output logic [DIR_W-1:0] dirb_o,
  output logic [1:0]       ope_o,
  output logic [N-1:0]     resultado_o,
  output logic             c_o,
  output logic             valido_o,
  output logic [N-1:0]     firma_o,
  output logic             ocupado_o,
  output logic             fin_o
);

  // The settle counter is 4 bits wide because LAT is at most 15.
  localparam logic [3:0]       LAT_C   = LAT[3:0];
  localparam logic [DIR_W-1:0] DIR_MAX = {DIR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ESPERA, PAUSA} estado_t;

  estado_t          estado_q, estado_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             modo_q, modo_d;
  logic [DIR_W-1:0] dira_q, dira_d, dirb_q, dirb_d;
  logic [1:0]       ope_q, ope_d;
  logic [N-1:0]     res_q, res_d, firma_q, firma_d;
  logic             c_q, c_d, valido_q, valido_d, ocupado_q, ocupado_d, fin_q, fin_d;

  logic             ultimo;
  logic [DIR_W-1:0] dira_sig, dirb_sig;

  // Last-pair detection and the row-major successor of the current address pair.
  always_comb begin
    ultimo   = (dira_q == DIR_MAX) && (dirb_q == DIR_MAX);
    dirb_sig = dirb_q + 1'b1;
    dira_sig = (dirb_q == DIR_MAX) ? dira_q + 1'b1 : dira_q;
  end

  // Next-state and output logic. Everything holds by default, and the pulses default to 0.
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    modo_d    = modo_q;
    dira_d    = dira_q;
    dirb_d    = dirb_q;
    ope_d     = ope_q;
    res_d     = res_q;
    firma_d   = firma_q;
    c_d       = c_q;
    ocupado_d = ocupado_q;
    valido_d  = 1'b0;
    fin_d     = 1'b0;
    case (estado_q)
      IDLE: begin
        if (start_i) begin
          dira_d    = '0;
          dirb_d    = '0;
          ope_d     = operacion_i;
          modo_d    = modo_i;
          firma_d   = '0;
          ocupado_d = 1'b1;
          cnt_d     = LAT_C;
          estado_d  = ESPERA;
        end
      end
      ESPERA: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d    = resultado_i;
          c_d      = c_alu_i;
          firma_d  = firma_q ^ resultado_i;
          valido_d = 1'b1;
          if (ultimo) begin
            fin_d     = 1'b1;
            ocupado_d = 1'b0;
            estado_d  = IDLE;
          end else if (modo_q) begin
            dira_d = dira_sig;
            dirb_d = dirb_sig;
            cnt_d  = LAT_C;
          end else begin
            estado_d = PAUSA;
          end
        end
      end
      PAUSA: begin
        if (paso_i) begin
          dira_d   = dira_sig;
          dirb_d   = dirb_sig;
          cnt_d    = LAT_C;
          estado_d = ESPERA;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  // State register. The synchronous reset clears the state and every output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_q  <= IDLE;
      cnt_q     <= '0;
      modo_q    <= 1'b0;
      dira_q    <= '0;
      dirb_q    <= '0;
      ope_q     <= '0;
      res_q     <= '0;
      firma_q   <= '0;
      c_q       <= 1'b0;
      valido_q  <= 1'b0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      modo_q    <= modo_d;
      dira_q    <= dira_d;
      dirb_q    <= dirb_d;
      ope_q     <= ope_d;
      res_q     <= res_d;
      firma_q   <= firma_d;
      c_q       <= c_d;
      valido_q  <= valido_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end
  end

  assign dira_o      = dira_q;
  assign dirb_o      = dirb_q;
  assign ope_o       = ope_q;
  assign resultado_o = res_q;
  assign c_o         = c_q;
  assign valido_o    = valido_q;
  assign firma_o     = firma_q;
  assign ocupado_o   = ocupado_q;
  assign fin_o       = fin_q;

endmodule

// File: tb/tb_secuenciador_alu.sv
// Directed testbench for secuenciador_alu.
// Instance A uses LAT=1 and instance B uses LAT=0.
// The ALU model returns {dira,dirb} zero-extended. Instance B raises carry only on pair (15,15).
module tb_secuenciador_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        modo = 1'b0, paso = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        start_a = 1'b0, start_b = 1'b0;

  logic [3:0]  dira_a, dirb_a, dira_b, dirb_b;
  logic [1:0]  ope_a, ope_b;
  logic [31:0] res_a, firma_a, res_b, firma_b;
  logic        c_a, val_a, ocu_a, fin_a, c_b, val_b, ocu_b, fin_b;
  logic [31:0] alu_a, alu_b;
  logic        carry_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign alu_a   = {24'd0, dira_a, dirb_a};
  assign alu_b   = {24'd0, dira_b, dirb_b};
  assign carry_b = (dira_b == 4'hF) && (dirb_b == 4'hF);

  secuenciador_alu #(.DIR_W(4), .N(32), .LAT(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .modo_i(modo), .paso_i(paso),
    .operacion_i(op), .resultado_i(alu_a), .c_alu_i(1'b0),
    .dira_o(dira_a), .dirb_o(dirb_a), .ope_o(ope_a), .resultado_o(res_a), .c_o(c_a),
    .valido_o(val_a), .firma_o(firma_a), .ocupado_o(ocu_a), .fin_o(fin_a)
  );

  secuenciador_alu #(.DIR_W(4), .N(32), .LAT(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .modo_i(modo), .paso_i(paso),
    .operacion_i(op), .resultado_i(alu_b), .c_alu_i(carry_b),
    .dira_o(dira_b), .dirb_o(dirb_b), .ope_o(ope_b), .resultado_o(res_b), .c_o(c_b),
    .valido_o(val_b), .firma_o(firma_b), .ocupado_o(ocu_b), .fin_o(fin_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_dir"}, {24'd0, dira_a, dirb_a}, 32'd0);
    chk({tag, "_ope"}, {30'd0, ope_a}, 32'd0);
    chk({tag, "_res"}, res_a, 32'd0);
    chk({tag, "_firma"}, firma_a, 32'd0);
    chk({tag, "_flags"}, {28'd0, c_a, val_a, ocu_a, fin_a}, 32'd0);
  endtask

  initial begin
    bit hit;

    // Reset state.
    tick(); tick();
    chk_zero_a("rst_a");
    chk("rst_b_flags", {28'd0, c_b, val_b, ocu_b, fin_b}, 32'd0);
    rst = 1'b0;

    // Auto sweep with LAT=1 and op=2.
    modo = 1'b1; op = 2'd2; start_a = 1'b1;
    tick(); start_a = 1'b0;
    chk("a_start_dir", {24'd0, dira_a, dirb_a}, 32'd0);
    chk("a_start_ope", {30'd0, ope_a}, 32'd2);
    chk("a_start_ocu", {31'd0, ocu_a}, 32'd1);
    tick();
    chk("a_val_e1", {31'd0, val_a}, 32'd0);
    tick();
    chk("a_val_first", {31'd0, val_a}, 32'd1);
    chk("a_res_first", res_a, 32'd0);
    for (int k = 1; k < 256; k++) begin
      tick();
      chk("a_val_gap", {31'd0, val_a}, 32'd0);
      if (k == 50) begin start_a = 1'b1; op = 2'd3; end
      tick();
      if (k == 50) begin start_a = 1'b0; op = 2'd2; end
      chk($sformatf("a_val_%0d", k), {31'd0, val_a}, 32'd1);
      chk($sformatf("a_res_%0d", k), res_a, k);
      chk($sformatf("a_fin_%0d", k), {31'd0, fin_a}, (k == 255) ? 32'd1 : 32'd0);
    end
    $display("auto sweep LAT=1 done, firma=%0h", firma_a);
    chk("a_ope_hold", {30'd0, ope_a}, 32'd2);
    chk("a_firma_end", firma_a, 32'd0);
    chk("a_ocu_end", {31'd0, ocu_a}, 32'd0);
    tick();
    chk("a_idle_pulses", {30'd0, val_a, fin_a}, 32'd0);
    chk("a_idle_res", res_a, 32'hFF);

    // Reset during a sweep at pair (2,5).
    start_a = 1'b1;
    tick(); start_a = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (dira_a == 4'd2 && dirb_a == 4'd5) hit = 1'b1;
      else tick();
    end
    chk("a_reach_2_5", {31'd0, hit}, 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk_zero_a("rst_mid");
    $display("reset mid-sweep checked");
    start_a = 1'b1;
    tick(); start_a = 1'b0;
    chk("a_restart_dir", {24'd0, dira_a, dirb_a}, 32'd0);
    chk("a_restart_ocu", {31'd0, ocu_a}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;

    // Step mode.
    modo = 1'b0; start_a = 1'b1;
    tick(); start_a = 1'b0; modo = 1'b1;
    tick(); tick();
    chk("s_val0", {31'd0, val_a}, 32'd1);
    chk("s_res0", res_a, 32'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("s_hold_dir", {24'd0, dira_a, dirb_a}, 32'd0);
    chk("s_hold_flags", {29'd0, val_a, ocu_a, fin_a}, 32'd2);
    paso = 1'b1;
    tick(); paso = 1'b0;
    chk("s_step_dir", {24'd0, dira_a, dirb_a}, 32'd1);
    tick();
    chk("s_val_wait", {31'd0, val_a}, 32'd0);
    tick();
    chk("s_val1", {31'd0, val_a}, 32'd1);
    chk("s_res1", res_a, 32'd1);
    chk("s_firma1", firma_a, 32'd1);
    $display("step mode checked");
    rst = 1'b1; tick(); rst = 1'b0;

    // LAT=0, back-to-back sweeps with start held high.
    modo = 1'b1; start_b = 1'b1;
    tick();
    tick();
    chk("b_val0", {31'd0, val_b}, 32'd1);
    chk("b_res0", res_b, 32'd0);
    for (int k = 1; k < 256; k++) begin
      tick();
      chk($sformatf("b_val_%0d", k), {31'd0, val_b}, 32'd1);
      chk($sformatf("b_res_%0d", k), res_b, k);
      if (k >= 254) begin
        chk($sformatf("b_c_%0d", k), {31'd0, c_b}, (k == 255) ? 32'd1 : 32'd0);
        chk($sformatf("b_fin_%0d", k), {31'd0, fin_b}, (k == 255) ? 32'd1 : 32'd0);
      end
    end
    chk("b_firma_end", firma_b, 32'd0);
    tick();
    chk("b_b2b_dir", {24'd0, dira_b, dirb_b}, 32'd0);
    chk("b_b2b_firma", firma_b, 32'd0);
    chk("b_b2b_ocu", {31'd0, ocu_b}, 32'd1);
    chk("b_b2b_fin", {31'd0, fin_b}, 32'd0);
    $display("LAT=0 back-to-back checked");
    start_b = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
